// File: rtl/seg7_scan_driver.sv
// Multiplexed active-low 7-segment driver showing the last DIGITS distinct values of cnt_in.
// Digit 0 shows the newest value and digit DIGITS-1 the oldest.
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic              upd
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [3:0]        cnt_q;
    logic [3:0]        hist_q [DIGITS];
    logic [IW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              presc_wrap;
    logic              change;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_d;
    logic              dp_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_wrap = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        change = (cnt_in != cnt_q);
        an_d   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = (idx_q != IW'(i));
        end
        // Outputs follow the pre-edge index/history, giving one cycle of latency.
        seg_d = decode(hist_q[idx_q]);
        dp_d  = (idx_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'h0;
            for (int i = 0; i < DIGITS; i++) begin
                hist_q[i] <= 4'h0;
            end
            idx_q   <= '0;
            presc_q <= '0;
            seg     <= 7'h7F;
            an      <= '1;
            dp      <= 1'b1;
            upd     <= 1'b0;
        end else begin
            cnt_q   <= cnt_in;
            if (change) begin
                hist_q[0] <= cnt_in;
                for (int i = 1; i < DIGITS; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
            end
            idx_q   <= idx_d;
            presc_q <= presc_d;
            seg     <= seg_d;
            an      <= an_d;
            dp      <= dp_d;
            upd     <= change;
        end
    end

endmodule
